// File: rtl/decode_pkg.sv
// Shared types, constants and field helper for the decode stage.
// Optional illegal-opcode flag is compiled in with DECODE_ILLEGAL_DETECT_EN.
package decode_pkg;

  localparam int DEF_OPCODE_W   = 3;
  localparam int DEF_REG_ADDR_W = 4;
  localparam int DEF_IMM_W      = 5;
  localparam int DEF_DATA_W     = 16;

  localparam logic [2:0] OPC_STORE = 3'b101;

  localparam int         N_ILLEGAL = 1;
  localparam logic [2:0] ILLEGAL_OPCODES [N_ILLEGAL] = '{3'b111};

  // Widest instruction the field helper can slice.
  localparam int FX_W = 64;

  typedef struct packed {
    logic [DEF_OPCODE_W-1:0]   op_code;
    logic                      beq_en;
    logic [DEF_REG_ADDR_W-1:0] dest_addr;
    logic [DEF_REG_ADDR_W-1:0] src_addr_a;
    logic [DEF_REG_ADDR_W-1:0] src_addr_b;
    logic [DEF_IMM_W-1:0]      immediate;
    logic [DEF_DATA_W-1:0]     imm_sext;
`ifdef DECODE_ILLEGAL_DETECT_EN
    logic                      illegal;
`endif
  } decoded_t;

  function automatic logic [FX_W-1:0] field_extract(input logic [FX_W-1:0] word,
                                                    input int unsigned    lsb,
                                                    input int unsigned    width);
    logic [FX_W-1:0] mask;
    mask = (width >= FX_W) ? '1 : ((FX_W'(1) << width) - FX_W'(1));
    return (word >> lsb) & mask;
  endfunction

endpackage

// File: rtl/decode_fields.sv
// Combinational instruction field extractor with immediate sign-extension, no state.
// Adds the illegal-opcode flag when DECODE_ILLEGAL_DETECT_EN is defined.
module decode_fields
  import decode_pkg::*;
#(
  parameter int                    INSTR_W      = 16,
  parameter int                    OPCODE_W     = 3,
  parameter int                    REG_ADDR_W   = 4,
  parameter int                    IMM_W        = 5,
  parameter int                    DATA_W       = 16,
  parameter logic [OPCODE_W-1:0]   STORE_OPCODE = OPCODE_W'(OPC_STORE)
) (
  input  logic [INSTR_W-1:0]    i_instr,
  output logic [OPCODE_W-1:0]   o_op_code,
  output logic                  o_beq_en,
  output logic [REG_ADDR_W-1:0] o_dest_addr,
  output logic [REG_ADDR_W-1:0] o_src_addr_a,
  output logic [REG_ADDR_W-1:0] o_src_addr_b,
  output logic [IMM_W-1:0]      o_immediate,
  output logic [DATA_W-1:0]     o_imm_sext
`ifdef DECODE_ILLEGAL_DETECT_EN
  ,
  output logic                  o_illegal
`endif
);

  localparam int SRCA_LSB = OPCODE_W + REG_ADDR_W;
  localparam int SRCB_LSB = OPCODE_W + 2*REG_ADDR_W;
  localparam int IMM_LSB  = INSTR_W - IMM_W;

  if (INSTR_W > FX_W) begin : g_width_chk
    $fatal(1, "decode_fields: INSTR_W exceeds field helper width");
  end

  logic [FX_W-1:0]       w_word;
  logic [REG_ADDR_W-1:0] w_src_b_raw;

  assign w_word       = FX_W'(i_instr);
  assign o_op_code    = OPCODE_W'(field_extract(w_word, 0, OPCODE_W));
  assign o_beq_en     = 1'(field_extract(w_word, OPCODE_W, 1));
  assign o_dest_addr  = REG_ADDR_W'(field_extract(w_word, OPCODE_W, REG_ADDR_W));
  assign o_src_addr_a = REG_ADDR_W'(field_extract(w_word, SRCA_LSB, REG_ADDR_W));
  assign w_src_b_raw  = REG_ADDR_W'(field_extract(w_word, SRCB_LSB, REG_ADDR_W));
  assign o_immediate  = IMM_W'(field_extract(w_word, IMM_LSB, IMM_W));

  // Stores carry their data register in the dest slot.
  assign o_src_addr_b = (o_op_code == STORE_OPCODE) ? o_dest_addr : w_src_b_raw;
  assign o_imm_sext   = DATA_W'($signed(o_immediate));

`ifdef DECODE_ILLEGAL_DETECT_EN
  always_comb begin
    o_illegal = 1'b0;
    for (int i = 0; i < N_ILLEGAL; i++) begin
      if (o_op_code == OPCODE_W'(ILLEGAL_OPCODES[i])) o_illegal = 1'b1;
    end
  end
`endif

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: 1-cycle latency, main+skid entries, in_ready registered (=!skid valid).
// Flush drops both entries; saturating output counter; illegal flag with DECODE_ILLEGAL_DETECT_EN.
module decode_stage
  import decode_pkg::*;
#(
  parameter int                  INSTR_W      = 16,
  parameter int                  OPCODE_W     = 3,
  parameter int                  REG_ADDR_W   = 4,
  parameter int                  IMM_W        = 5,
  parameter int                  DATA_W       = 16,
  parameter logic [OPCODE_W-1:0] STORE_OPCODE = OPCODE_W'(OPC_STORE),
  parameter int                  CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [INSTR_W-1:0]    instruction,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OPCODE_W-1:0]   op_code,
  output logic                  beq_en,
  output logic [REG_ADDR_W-1:0] dest_addr,
  output logic [REG_ADDR_W-1:0] src_addr_a,
  output logic [REG_ADDR_W-1:0] src_addr_b,
  output logic [IMM_W-1:0]      immediate,
  output logic [DATA_W-1:0]     imm_sext,
  output logic [CNT_W-1:0]      decoded_count
`ifdef DECODE_ILLEGAL_DETECT_EN
  ,
  output logic                  illegal
`endif
);

  if ((OPCODE_W + 3*REG_ADDR_W > INSTR_W) || (IMM_W > DATA_W)) begin : g_param_chk
    $fatal(1, "decode_stage: field widths do not fit the instruction/data width");
  end

  typedef struct packed {
    logic [OPCODE_W-1:0]   op_code;
    logic                  beq_en;
    logic [REG_ADDR_W-1:0] dest_addr;
    logic [REG_ADDR_W-1:0] src_addr_a;
    logic [REG_ADDR_W-1:0] src_addr_b;
    logic [IMM_W-1:0]      immediate;
    logic [DATA_W-1:0]     imm_sext;
`ifdef DECODE_ILLEGAL_DETECT_EN
    logic                  illegal;
`endif
  } entry_t;

  logic [OPCODE_W-1:0]   w_op_code;
  logic                  w_beq_en;
  logic [REG_ADDR_W-1:0] w_dest_addr;
  logic [REG_ADDR_W-1:0] w_src_addr_a;
  logic [REG_ADDR_W-1:0] w_src_addr_b;
  logic [IMM_W-1:0]      w_immediate;
  logic [DATA_W-1:0]     w_imm_sext;
`ifdef DECODE_ILLEGAL_DETECT_EN
  logic                  w_illegal;
`endif

  decode_fields #(
    .INSTR_W      (INSTR_W),
    .OPCODE_W     (OPCODE_W),
    .REG_ADDR_W   (REG_ADDR_W),
    .IMM_W        (IMM_W),
    .DATA_W       (DATA_W),
    .STORE_OPCODE (STORE_OPCODE)
  ) u_fields (
    .i_instr      (instruction),
    .o_op_code    (w_op_code),
    .o_beq_en     (w_beq_en),
    .o_dest_addr  (w_dest_addr),
    .o_src_addr_a (w_src_addr_a),
    .o_src_addr_b (w_src_addr_b),
    .o_immediate  (w_immediate),
    .o_imm_sext   (w_imm_sext)
`ifdef DECODE_ILLEGAL_DETECT_EN
    ,
    .o_illegal    (w_illegal)
`endif
  );

  entry_t w_dec;
  always_comb begin
    w_dec            = '0;
    w_dec.op_code    = w_op_code;
    w_dec.beq_en     = w_beq_en;
    w_dec.dest_addr  = w_dest_addr;
    w_dec.src_addr_a = w_src_addr_a;
    w_dec.src_addr_b = w_src_addr_b;
    w_dec.immediate  = w_immediate;
    w_dec.imm_sext   = w_imm_sext;
`ifdef DECODE_ILLEGAL_DETECT_EN
    w_dec.illegal    = w_illegal;
`endif
  end

  entry_t           r_m;
  entry_t           r_s;
  logic             r_m_vld;
  logic             r_s_vld;
  logic             r_in_rdy;
  logic [CNT_W-1:0] r_cnt;

  logic w_hs_in;
  logic w_hs_out;
  logic w_advance;
  logic w_m_vld_nxt;
  logic w_s_vld_nxt;
  logic w_m_ld_s;
  logic w_m_ld_dec;
  logic w_s_ld;

  assign w_hs_in   = in_valid & r_in_rdy;
  assign w_hs_out  = r_m_vld & out_ready;
  assign w_advance = !r_m_vld | out_ready;

  always_comb begin
    w_m_vld_nxt = r_m_vld;
    w_s_vld_nxt = r_s_vld;
    w_m_ld_s    = 1'b0;
    w_m_ld_dec  = 1'b0;
    w_s_ld      = 1'b0;
    if (flush) begin
      w_m_vld_nxt = 1'b0;
      w_s_vld_nxt = 1'b0;
    end else if (w_advance) begin
      // in_ready is low whenever the skid is full, so no input competes with it here.
      if (r_s_vld) begin
        w_m_ld_s    = 1'b1;
        w_m_vld_nxt = 1'b1;
        w_s_vld_nxt = 1'b0;
      end else if (w_hs_in) begin
        w_m_ld_dec  = 1'b1;
        w_m_vld_nxt = 1'b1;
      end else begin
        w_m_vld_nxt = 1'b0;
      end
    end else if (w_hs_in) begin
      w_s_ld      = 1'b1;
      w_s_vld_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_m      <= '0;
      r_s      <= '0;
      r_m_vld  <= 1'b0;
      r_s_vld  <= 1'b0;
      r_in_rdy <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_m_vld  <= w_m_vld_nxt;
      r_s_vld  <= w_s_vld_nxt;
      r_in_rdy <= !w_s_vld_nxt;
      if (w_m_ld_s)   r_m <= r_s;
      if (w_m_ld_dec) r_m <= w_dec;
      if (w_s_ld)     r_s <= w_dec;
      if (w_hs_out && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready      = r_in_rdy;
  assign out_valid     = r_m_vld;
  assign op_code       = r_m.op_code;
  assign beq_en        = r_m.beq_en;
  assign dest_addr     = r_m.dest_addr;
  assign src_addr_a    = r_m.src_addr_a;
  assign src_addr_b    = r_m.src_addr_b;
  assign immediate     = r_m.immediate;
  assign imm_sext      = r_m.imm_sext;
  assign decoded_count = r_cnt;
`ifdef DECODE_ILLEGAL_DETECT_EN
  assign illegal       = r_m.illegal;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus random traffic against a 2-deep queue model.
// A second instance with a 2-bit counter covers saturation.
module tb_decode_stage;
  import decode_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] instruction;

  logic        in_ready, out_valid, beq_en;
  logic [2:0]  op_code;
  logic [3:0]  dest_addr, src_addr_a, src_addr_b;
  logic [4:0]  immediate;
  logic [15:0] imm_sext, decoded_count;

  logic        s_in_ready, s_out_valid, s_beq_en;
  logic [2:0]  s_op_code;
  logic [3:0]  s_dest_addr, s_src_addr_a, s_src_addr_b;
  logic [4:0]  s_immediate;
  logic [15:0] s_imm_sext;
  logic [1:0]  s_decoded_count;
`ifdef DECODE_ILLEGAL_DETECT_EN
  logic        illegal, s_illegal;
`endif

  decode_stage u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_code(op_code), .beq_en(beq_en), .dest_addr(dest_addr),
    .src_addr_a(src_addr_a), .src_addr_b(src_addr_b),
    .immediate(immediate), .imm_sext(imm_sext), .decoded_count(decoded_count)
`ifdef DECODE_ILLEGAL_DETECT_EN
    , .illegal(illegal)
`endif
  );

  decode_stage #(.CNT_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .instruction(instruction),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .op_code(s_op_code), .beq_en(s_beq_en), .dest_addr(s_dest_addr),
    .src_addr_a(s_src_addr_a), .src_addr_b(s_src_addr_b),
    .immediate(s_immediate), .imm_sext(s_imm_sext), .decoded_count(s_decoded_count)
`ifdef DECODE_ILLEGAL_DETECT_EN
    , .illegal(s_illegal)
`endif
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  decoded_t    q[$];
  int unsigned m_cnt;
  int unsigned m_cnt_sat;

  function automatic decoded_t ref_decode(input logic [15:0] ins);
    decoded_t    d;
    int unsigned v, imm;
    v = 32'(ins);
    d = '0;
    d.op_code    = 3'(v % 8);
    d.beq_en     = 1'((v / 8) % 2);
    d.dest_addr  = 4'((v / 8) % 16);
    d.src_addr_a = 4'((v / 128) % 16);
    d.src_addr_b = ((v % 8) == 5) ? d.dest_addr : 4'((v / 2048) % 16);
    imm          = v / 2048;
    d.immediate  = 5'(imm);
    d.imm_sext   = (imm >= 16) ? 16'(imm + 65536 - 32) : 16'(imm);
`ifdef DECODE_ILLEGAL_DETECT_EN
    d.illegal    = ((v % 8) == 7);
`endif
    return d;
  endfunction

  task automatic check_outputs();
    decoded_t e;
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("in_ready", 32'(in_ready), 32'(q.size() < 2));
    check("count", 32'(decoded_count), m_cnt);
    check("count_sat", 32'(s_decoded_count), m_cnt_sat);
    check("sat_out_valid", 32'(s_out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      e = q[0];
      check("op_code", 32'(op_code), 32'(e.op_code));
      check("beq_en", 32'(beq_en), 32'(e.beq_en));
      check("dest_addr", 32'(dest_addr), 32'(e.dest_addr));
      check("src_addr_a", 32'(src_addr_a), 32'(e.src_addr_a));
      check("src_addr_b", 32'(src_addr_b), 32'(e.src_addr_b));
      check("immediate", 32'(immediate), 32'(e.immediate));
      check("imm_sext", 32'(imm_sext), 32'(e.imm_sext));
`ifdef DECODE_ILLEGAL_DETECT_EN
      check("illegal", 32'(illegal), 32'(e.illegal));
`endif
    end
  endtask

  // Called at a falling edge: check, drive, advance the model past the next rising edge.
  task automatic step(input logic f, input logic iv, input logic [15:0] ins, input logic ordy);
    logic ov, ir;
    check_outputs();
    flush       = f;
    in_valid    = iv;
    instruction = ins;
    out_ready   = ordy;
    ov = (q.size() > 0);
    ir = (q.size() < 2);
    if (ov && ordy) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_sat < 3) m_cnt_sat++;
    end
    if (f) q.delete();
    else begin
      if (ov && ordy) void'(q.pop_front());
      if (iv && ir) q.push_back(ref_decode(ins));
    end
    @(negedge clk);
  endtask

  logic [1:0] sat_exp [5];

  initial begin
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instruction = '0;
    m_cnt = 0; m_cnt_sat = 0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(decoded_count), 32'd0);
    check("rst_imm_sext", 32'(imm_sext), 32'd0);
    check("rst_op_code", 32'(op_code), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic decode
    step(1'b0, 1'b1, 16'hA191, 1'b1);
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_op", 32'(op_code), 32'd1);
    check("basic_beq", 32'(beq_en), 32'd0);
    check("basic_dest", 32'(dest_addr), 32'd2);
    check("basic_srca", 32'(src_addr_a), 32'd3);
    check("basic_srcb", 32'(src_addr_b), 32'd4);
    check("basic_imm", 32'(immediate), 32'b10100);
    check("basic_sext", 32'(imm_sext), 32'hFFF4);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check("basic_count", 32'(decoded_count), 32'd1);

    // Store source select
    step(1'b0, 1'b1, 16'h0035, 1'b1);
    check("store_srcb", 32'(src_addr_b), 32'd6);
    check("store_dest", 32'(dest_addr), 32'd6);
    check("store_sext", 32'(imm_sext), 32'd0);
    step(1'b0, 1'b1, 16'h0034, 1'b1);
    check("nonstore_srcb", 32'(src_addr_b), 32'd0);
    step(1'b0, 1'b0, 16'h0000, 1'b1);

    // Backpressure with skid fill
    step(1'b0, 1'b1, 16'h0001, 1'b0);
    step(1'b0, 1'b1, 16'h0002, 1'b0);
    step(1'b0, 1'b1, 16'h0003, 1'b0);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_hold_op", 32'(op_code), 32'd1);
    step(1'b0, 1'b1, 16'h0003, 1'b0);
    check("bp_hold_op2", 32'(op_code), 32'd1);
    step(1'b0, 1'b1, 16'h0003, 1'b1);
    check("bp_second", 32'(op_code), 32'd2);
    step(1'b0, 1'b1, 16'h0003, 1'b1);
    check("bp_third", 32'(op_code), 32'd3);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check("bp_count", 32'(decoded_count), 32'd6);
    check("bp_drained", 32'(out_valid), 32'd0);

    // Flush while both entries are full
    step(1'b0, 1'b1, 16'h0011, 1'b0);
    step(1'b0, 1'b1, 16'h0012, 1'b0);
    step(1'b1, 1'b1, 16'h0013, 1'b0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_count", 32'(decoded_count), 32'd6);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000, 1'b1);

    // Asynchronous reset mid-stream
    step(1'b0, 1'b1, 16'h0021, 1'b0);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_count", 32'(decoded_count), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    q.delete(); m_cnt = 0; m_cnt_sat = 0;
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0000, 1'b1);

    // Counter saturation on the 2-bit instance; opcodes 7 and 1 exercise the illegal flag
    for (int i = 0; i < 6; i++) begin
      step(1'b0, (i < 5), (i % 2 == 0) ? 16'h0007 : 16'h0001, 1'b1);
`ifdef DECODE_ILLEGAL_DETECT_EN
      if (i == 0) check("illegal_op7", 32'(illegal), 32'd1);
      if (i == 1) check("illegal_op1", 32'(illegal), 32'd0);
`endif
      if (i > 0) check("sat_seq", 32'(s_decoded_count), 32'(sat_exp[i-1]));
    end

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic f, iv, ordy;
      f    = ($urandom_range(0, 24) == 0);
      iv   = ($urandom_range(0, 2) != 0);
      ordy = f ? 1'b0 : ($urandom_range(0, 3) != 0);
      step(f, iv, 16'($urandom), ordy);
    end
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    check_outputs();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
